aes_round_ctrl: RTL and testbench

- Round controller and state register for the AES-128 encrypt datapath.
- Sits directly upstream of the byte substitution stage and drives its data_in, count_out and data_to_store inputs.
- Captures each round's result from the shift-rows/mix-columns/add-round-key path and feeds it back for the next round.
- Sequences NR rounds, stalls on round-key availability, and presents the final ciphertext with a one-cycle valid pulse.

---
 rtl/aes_round_ctrl.sv | 120 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 encrypt round controller: it holds the plaintext and the running round state,
// steps the round index as round keys arrive, and pulses data_valid with the ciphertext.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int DW = 128,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    input  logic          key_ready,
    input  logic [DW-1:0] round_result,
    output logic [DW-1:0] plain_out,
    output logic [CW-1:0] count_out,
    output logic [DW-1:0] data_to_store,
    output logic          busy,
    output logic          data_valid,
    output logic [DW-1:0] data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [DW-1:0] r_plain;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_store;
    logic          r_busy;
    logic          r_valid;
    logic [DW-1:0] r_dataOut;
    logic          w_lastRound;

    assign w_lastRound = (r_count == CW'(NR - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_ROUND;
                end
            end
            S_ROUND: begin
                if (key_ready && w_lastRound) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // A low key_ready in ROUND stalls every register, so each such cycle adds one cycle of latency.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_plain   <= '0;
            r_count   <= '0;
            r_store   <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_dataOut <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_plain <= data_in;
                        r_count <= '0;
                        r_store <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ROUND: begin
                    if (key_ready) begin
                        if (w_lastRound) begin
                            r_dataOut <= round_result;
                            r_valid   <= 1'b1;
                        end else begin
                            r_store <= round_result;
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign plain_out     = r_plain;
    assign count_out     = r_count;
    assign data_to_store = r_store;
    assign busy          = r_busy;
    assign data_valid    = r_valid;
    assign data_out      = r_dataOut;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: an XOR round stub checks sequencing, and a
// behavioural AES round model checks the FIPS-197 Appendix B block end to end.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int DW = 128;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          key_ready = 1'b0;
    logic [DW-1:0] round_result;
    logic [DW-1:0] plain_out;
    logic [CW-1:0] count_out;
    logic [DW-1:0] data_to_store;
    logic          busy;
    logic          data_valid;
    logic [DW-1:0] data_out;

    int testsRun = 0;
    int testsFailed = 0;
    bit aesMode = 1'b0;

    logic [7:0]   sbox [256];
    logic [127:0] rk [11];

    aes_round_ctrl #(.NR(NR), .DW(DW), .CW(CW)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .data_in(data_in),
        .key_ready(key_ready),
        .round_result(round_result),
        .plain_out(plain_out),
        .count_out(count_out),
        .data_to_store(data_to_store),
        .busy(busy),
        .data_valid(data_valid),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // SubBytes, ShiftRows and (except in the last round) MixColumns; byte 0 is the MSB.
    function automatic logic [127:0] aesRound(input logic [127:0] st, input bit last);
        logic [7:0]   t [16];
        logic [7:0]   u [16];
        logic [7:0]   m [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) t[i] = sbox[st[127-8*i -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                u[r+4*c] = t[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            m[4*c+0] = last ? u[4*c+0] : gmul(u[4*c], 8'h02) ^ gmul(u[4*c+1], 8'h03) ^ u[4*c+2] ^ u[4*c+3];
            m[4*c+1] = last ? u[4*c+1] : u[4*c] ^ gmul(u[4*c+1], 8'h02) ^ gmul(u[4*c+2], 8'h03) ^ u[4*c+3];
            m[4*c+2] = last ? u[4*c+2] : u[4*c] ^ u[4*c+1] ^ gmul(u[4*c+2], 8'h02) ^ gmul(u[4*c+3], 8'h03);
            m[4*c+3] = last ? u[4*c+3] : gmul(u[4*c], 8'h03) ^ u[4*c+1] ^ u[4*c+2] ^ gmul(u[4*c+3], 8'h02);
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = m[i];
        return res;
    endfunction

    function automatic logic [127:0] aesStub(input logic [127:0] plain, input logic [127:0] store,
                                             input logic [3:0] cnt);
        int c;
        logic [127:0] inState;
        c = int'(cnt);
        if (c > NR - 1) c = NR - 1;
        inState = (c == 0) ? (plain ^ rk[0]) : store;
        return aesRound(inState, c == NR - 1) ^ rk[c+1];
    endfunction

    always_comb begin
        round_result = data_to_store ^ {124'b0, count_out};
        if (aesMode) round_result = aesStub(plain_out, data_to_store, count_out);
    end

    typedef struct {
        string        name;
        logic [127:0] din;
        bit           useAes;
        int           stallAt;
        int           stallLen;
        int           ignoreAt;
        bit           startInDone;
        int           expLat;
        logic [127:0] expOut;
    } vec_t;

    vec_t vecs [4];

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Runs one block with a cycle-by-cycle model of the round index and valid pulse.
    task automatic applyStimulus(input vec_t v);
        int edges;
        int expCount;
        int stallLeft;
        int dutEdge;
        bit expValid;
        aesMode = v.useAes;
        key_ready = 1'b1;
        start = 1'b1;
        data_in = v.din;
        @(posedge clk); #1;
        start = 1'b0;
        data_in = ~v.din;
        checkOutput({v.name, " busy after accept"}, 128'(busy), 128'(1));
        checkOutput({v.name, " count after accept"}, 128'(count_out), 128'(0));
        checkOutput({v.name, " plain_out captured"}, plain_out, v.din);
        checkOutput({v.name, " store cleared"}, data_to_store, 128'(0));
        edges = 0;
        expCount = 0;
        stallLeft = v.stallLen;
        dutEdge = -1;
        expValid = 1'b0;
        while (!expValid && edges < 40) begin
            key_ready = !(expCount == v.stallAt && stallLeft > 0);
            if (!key_ready) stallLeft--;
            start = (expCount == v.ignoreAt);
            @(posedge clk); #1;
            edges++;
            if (key_ready) begin
                if (expCount == NR - 1) expValid = 1'b1;
                else expCount++;
            end
            if (data_valid && dutEdge < 0) dutEdge = edges;
            checkOutput({v.name, " count_out"}, 128'(count_out), 128'(expCount));
            checkOutput({v.name, " data_valid"}, 128'(data_valid), 128'(expValid));
            checkOutput({v.name, " plain_out hold"}, plain_out, v.din);
        end
        if (!expValid) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s timeout: got no completion, expected one within 40 cycles", v.name);
        end
        checkOutput({v.name, " latency"}, 128'(dutEdge), 128'(v.expLat));
        checkOutput({v.name, " data_out"}, data_out, v.expOut);
        checkOutput({v.name, " busy in DONE"}, 128'(busy), 128'(1));
        start = v.startInDone;
        key_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({v.name, " valid single pulse"}, 128'(data_valid), 128'(0));
        checkOutput({v.name, " busy falls"}, 128'(busy), 128'(0));
        checkOutput({v.name, " count back to 0"}, 128'(count_out), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        checkOutput({v.name, " no restart"}, 128'(busy), 128'(0));
        checkOutput({v.name, " no extra valid"}, 128'(data_valid), 128'(0));
        checkOutput({v.name, " data_out retained"}, data_out, v.expOut);
        checkOutput({v.name, " plain_out retained"}, plain_out, v.din);
    endtask

    initial begin
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        logic [7:0]  inv;
        logic [7:0]  b;
        logic [127:0] key;
        bit sawValid;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        vecs[0] = '{"nominal", 128'h00112233445566778899aabbccddeeff, 1'b0, -1, 0, -1, 1'b0, 10, 128'h1};
        vecs[1] = '{"stall", 128'h00112233445566778899aabbccddeeff, 1'b0, 4, 3, -1, 1'b0, 13, 128'h1};
        vecs[2] = '{"ignored start", 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b0, -1, 0, 5, 1'b1, 10, 128'h1};
        vecs[3] = '{"fips197", 128'h3243f6a8885a308d313198a2e0370734, 1'b1, -1, 0, -1, 1'b0, 10,
                    128'h3925841d02dc09fbdc118597196a0b32};

        // Reset is held while start is high and data_in is all ones.
        n_rst = 1'b0;
        start = 1'b1;
        data_in = '1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset plain_out", plain_out, 128'(0));
        checkOutput("reset count_out", 128'(count_out), 128'(0));
        checkOutput("reset data_to_store", data_to_store, 128'(0));
        checkOutput("reset busy", 128'(busy), 128'(0));
        checkOutput("reset data_valid", 128'(data_valid), 128'(0));
        checkOutput("reset data_out", data_out, 128'(0));
        start = 1'b0;
        n_rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("post-reset busy", 128'(busy), 128'(0));
        checkOutput("post-reset plain_out", plain_out, 128'(0));

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Reset pulsed mid-block must clear everything without a clock edge.
        aesMode = 1'b0;
        key_ready = 1'b1;
        start = 1'b1;
        data_in = 128'h00112233445566778899aabbccddeeff;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (count_out == 4'd7) break;
            @(posedge clk); #1;
        end
        checkOutput("midreset reached count 7", 128'(count_out), 128'(7));
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("midreset async count_out", 128'(count_out), 128'(0));
        checkOutput("midreset async busy", 128'(busy), 128'(0));
        checkOutput("midreset async plain_out", plain_out, 128'(0));
        checkOutput("midreset async data_to_store", data_to_store, 128'(0));
        checkOutput("midreset async data_out", data_out, 128'(0));
        checkOutput("midreset async data_valid", 128'(data_valid), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        sawValid = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (data_valid || busy) sawValid = 1'b1;
        end
        checkOutput("midreset no valid afterwards", 128'(sawValid), 128'(0));
        applyStimulus(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        testsFailed++;
        $display("[TB] FAIL watchdog: got no finish, expected one before 200000 time units");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
